pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers plus PC).
- Generates per-stage enable/flush strobes for three cases: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory waits.
- A registered FSM with a timeout counter guards memory waits and raises a sticky error if memory never responds.

Parameters:
- MEM_TIMEOUT, 16: max consecutive MEM_WAIT cycles before error (range 2..255).
- CNT_W, 8: width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the clk edge).
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  MEM-stage instruction accesses data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads NOP (takes precedence over ifid_en=1 at the register).
- idex_en  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX loads bubble (all control signals 0).
- exmem_en  out  1  EX/MEM load enable.
- memwb_flush  out  1  MEM/WB loads bubble (WB control = 0).
- state  out  2  current FSM state, for debug.
- timeout_err  out  1  sticky memory-timeout flag.

Behaviour:
- FSM states: RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2. State, wait counter and timeout_err are registered; all strobes are combinational from state and current inputs.
- Reset (rst=0 at a clk edge): state=RUN, wait counter=0, timeout_err=0.
- Strobes while rst=0: pc_en=ifid_en=idex_en=exmem_en=0; ifid_flush=idex_flush=memwb_flush=1.
- Default strobes (no hazard): all enables=1, all flushes=0.
- Priority order, highest first: ERR, memory freeze, branch flush, load-use stall.
- Memory freeze:
  - Condition: mem_req=1 and mem_ready=0, in RUN or MEM_WAIT.
  - Strobes: pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1, ifid_flush=idex_flush=0.
  - The freeze applies in the same cycle the condition is first seen; no added latency.
- Branch flush:
  - Condition: ex_branch_taken=1 and no freeze.
  - Strobes: ifid_flush=1, idex_flush=1, all enables=1.
  - A simultaneous load-use match is ignored, because the ID instruction is wrong-path.
- Load-use stall:
  - Condition: ex_memread=1, ex_rd!=0, and (id_use_rs1 and id_rs1==ex_rd, or id_use_rs2 and id_rs2==ex_rd).
  - Strobes: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1.
  - Lasts exactly 1 cycle, since the load leaves EX on the next edge.
  - ex_rd=0 never stalls.
- Transitions:
  - RUN -> MEM_WAIT when mem_req & !mem_ready; counter<=1.
  - MEM_WAIT -> RUN when mem_ready=1 (strobes that cycle are non-freeze; counter<=0).
  - MEM_WAIT -> MEM_WAIT on stay; counter<=counter+1.
  - MEM_WAIT -> ERR when mem_ready=0 and counter==MEM_TIMEOUT-1; timeout_err<=1.
  - If mem_req drops to 0 while in MEM_WAIT, return to RUN (access aborted); counter<=0.
- ERR: full freeze (same strobes as memory freeze); exits only via reset; timeout_err stays 1.
- A branch held in EX during a freeze is re-evaluated after release; the EX/MEM hold keeps it intact.
- Reset asserted mid-MEM_WAIT: the next edge returns to RUN with the counter cleared.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds output ports stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments each cycle pc_en=0 while rst=1.
  - flush_count increments each cycle the branch-flush condition wins priority.
  - Both are cleared by reset and wrap modulo 2^32.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> same cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle (ex_memread=0) all defaults.
- Branch vs load-use: ex_branch_taken=1 together with the load-use match above -> ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> freeze strobes for 3 cycles; state 0->1 on the first edge; state returns to 0 on the mem_ready cycle's edge; timeout_err=0.
- Timeout (MEM_TIMEOUT=16): mem_req=1, mem_ready=0 held -> after 16 cycles state=2, timeout_err=1, freeze persists with mem_ready=1; rst=0 for one edge -> state=0, timeout_err=0.
- Reset mid-wait: in MEM_WAIT with counter=7, rst=0 -> while rst=0 enables=0 and flushes=1; after the edge state=0 and counter=0.
- ex_rd=0 hazard: ex_memread=1, ex_rd=0, id_rs1=0, id_use_rs1=1 -> no stall, pc_en=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for a 5-stage pipeline (PC, IF/ID, ID/EX,
// EX/MEM, MEM/WB). It produces per-stage load enables and flush strobes for
// three situations, highest priority first:
//   ERR state / memory freeze > taken branch in EX > load-use hazard.
// A registered FSM (RUN, MEM_WAIT, ERR) with a wait counter guards
// multi-cycle data-memory accesses. If memory never answers, the FSM locks
// into ERR and raises a sticky timeout flag that only reset clears.
//
// Optional build macro: HAZARD_PERF_CNT_EN adds the stall_cycles and
// flush_count performance counters.
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-low reset
//   id_rs1/id_rs2   source registers of the ID instruction
//   id_use_rs1/2    ID instruction actually reads rs1 / rs2
//   ex_memread      EX instruction is a load
//   ex_rd           destination register of the EX instruction
//   ex_branch_taken branch/jump resolved taken in EX
//   mem_req         MEM instruction accesses data memory this cycle
//   mem_ready       data memory completes the access this cycle
//   pc_en, ifid_en, idex_en, exmem_en    stage load enables
//   ifid_flush, idex_flush, memwb_flush  stage bubble/NOP strobes
//   state           current FSM state (debug)
//   timeout_err     sticky memory-timeout flag
//   stall_cycles    (HAZARD_PERF_CNT_EN) cycles with pc_en=0 out of reset
//   flush_count     (HAZARD_PERF_CNT_EN) cycles a branch flush won priority
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       ex_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_en,
    output logic       idex_flush,
    output logic       exmem_en,
    output logic       memwb_flush,
    output logic [1:0] state,
    output logic       timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    // Last counter value that may still wait; the next miss becomes a timeout.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   wait_cnt_r;
    logic [CNT_W-1:0]   wait_cnt_next_s;
    logic               timeout_err_r;
    logic               timeout_err_next_s;

    logic               mem_pending_s;
    logic               freeze_s;
    logic               load_use_s;
    logic               branch_win_s;
    logic               rs1_hit_s;
    logic               rs2_hit_s;

    // Hazard condition decode shared by the FSM and the strobe logic.
    always_comb begin
        mem_pending_s = mem_req & ~mem_ready;
        rs1_hit_s     = id_use_rs1 & (id_rs1 == ex_rd);
        rs2_hit_s     = id_use_rs2 & (id_rs2 == ex_rd);
        // x0 is hard-wired to zero, so a load "into" it never creates a hazard.
        load_use_s    = ex_memread & (ex_rd != 5'd0) & (rs1_hit_s | rs2_hit_s);
        if ((state_r == RUN) || (state_r == MEM_WAIT)) begin
            freeze_s = mem_pending_s;
        end else begin
            freeze_s = 1'b0;
        end
    end

    // Next-state, wait counter and sticky error logic.
    always_comb begin
        state_next_s       = state_r;
        wait_cnt_next_s    = wait_cnt_r;
        timeout_err_next_s = timeout_err_r;
        case (state_r)
            RUN: begin
                if (mem_pending_s) begin
                    state_next_s    = MEM_WAIT;
                    wait_cnt_next_s = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_next_s    = RUN;
                    wait_cnt_next_s = {CNT_W{1'b0}};
                end
            end
            MEM_WAIT: begin
                if (!mem_req || mem_ready) begin
                    // Access completed or aborted: resume normal flow.
                    state_next_s    = RUN;
                    wait_cnt_next_s = {CNT_W{1'b0}};
                end else if (wait_cnt_r == LAST_WAIT) begin
                    state_next_s       = ERR;
                    timeout_err_next_s = 1'b1;
                end else begin
                    state_next_s    = MEM_WAIT;
                    wait_cnt_next_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ERR: begin
                // Locked until reset.
                state_next_s       = ERR;
                timeout_err_next_s = 1'b1;
            end
            default: begin
                state_next_s    = RUN;
                wait_cnt_next_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state, wait counter and error flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= RUN;
            wait_cnt_r    <= {CNT_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            wait_cnt_r    <= wait_cnt_next_s;
            timeout_err_r <= timeout_err_next_s;
        end
    end

    // Per-stage strobes, resolved in priority order.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_flush  = 1'b0;
        branch_win_s = 1'b0;
        if (!rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if ((state_r == ERR) || freeze_s) begin
            // Hold everything up to EX/MEM; the stalled MEM op must not
            // retire into WB, so MEM/WB takes a bubble.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            // IF and ID hold wrong-path instructions; any load-use match
            // against them is irrelevant.
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            branch_win_s = 1'b1;
        end else if (load_use_s) begin
            // One-cycle bubble: the load leaves EX on the next edge.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b0;
            idex_en     = 1'b1;
            idex_flush  = 1'b0;
            exmem_en    = 1'b1;
            memwb_flush = 1'b0;
        end
    end

    assign state       = state_r;
    assign timeout_err = timeout_err_r;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_count_r;

    // Performance counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_r <= 32'd0;
            flush_count_r  <= 32'd0;
        end else begin
            if (!pc_en) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (branch_win_s) begin
                flush_count_r <= flush_count_r + 32'd1;
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;
`endif

endmodule
